// File: rtl/dac_spi_tx.sv
// dac_spi_tx: formats 10-bit offset-binary samples into MCP4911 command words
// and shifts them out over SPI (CS/SCK/SDI) followed by an LDAC pulse.
// A single pending slot holds a sample that arrives while a frame is in flight.
module dac_spi_tx #(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       overrun,
  output logic       DAC_CS,
  output logic       DAC_SCK,
  output logic       DAC_SDI,
  output logic       DAC_LD
);

  localparam int            PW   = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_t;

  typedef struct packed {
    logic       vld;
    logic [9:0] data;
  } pend_t;

  // BUF=1, GA_n=1, SHDN_n=1, 10 data bits, 2 don't-care zeros
  function automatic logic [15:0] cmd_word(input logic [9:0] d);
    return {4'b0111, d, 2'b00};
  endfunction

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    bcnt, bcnt_n;
  logic          sck_lo, sck_lo_n;   // 0: SCK-high half of a bit, 1: SCK-low half
  logic [15:0]   shreg, shreg_n;
  pend_t         pend, pend_n;
  logic          ovr_n, ph_end;
  logic          cs_d, sck_d, sdi_d, ld_d, busy_d;

  // FSM state, counters, shift register and pending slot
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state  <= IDLE;
      presc  <= '0;
      bcnt   <= '0;
      sck_lo <= 1'b0;
      shreg  <= '0;
      pend   <= '0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      bcnt   <= bcnt_n;
      sck_lo <= sck_lo_n;
      shreg  <= shreg_n;
      pend   <= pend_n;
    end
  end

  // Next-state logic: phase timing, bit shifting and sample arbitration
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    bcnt_n   = bcnt;
    sck_lo_n = sck_lo;
    shreg_n  = shreg;
    pend_n   = pend;
    ovr_n    = 1'b0;
    ph_end   = (presc == PMAX);

    // every non-IDLE state is built from CLK_DIV-cycle phases
    if (state != IDLE) begin
      presc_n = ph_end ? '0 : presc + 1'b1;
      // a sample arriving mid-frame parks in the pending slot
      if (load) begin
        ovr_n  = pend.vld;
        pend_n = '{vld: 1'b1, data: data_in};
      end
    end

    case (state)
      IDLE: begin
        presc_n  = '0;
        bcnt_n   = 4'd15;
        sck_lo_n = 1'b0;
        if (pend.vld) begin
          // older pending sample goes first; a same-cycle load takes its slot
          shreg_n = cmd_word(pend.data);
          state_n = SETUP;
          pend_n  = '{vld: load, data: data_in};
        end else if (load) begin
          shreg_n = cmd_word(data_in);
          state_n = SETUP;
        end
      end
      SETUP: if (ph_end) state_n = SHIFT;
      SHIFT: begin
        if (ph_end) begin
          if (!sck_lo) begin
            // SCK falls here: advance to the next bit
            sck_lo_n = 1'b1;
            shreg_n  = {shreg[14:0], 1'b0};
          end else begin
            sck_lo_n = 1'b0;
            bcnt_n   = bcnt - 4'd1;
            if (bcnt == 4'd0) state_n = HOLD;
          end
        end
      end
      HOLD:    if (ph_end) state_n = LATCH;
      LATCH:   if (ph_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin values implied by the current state
  always_comb begin
    cs_d   = 1'b1;
    sck_d  = 1'b0;
    sdi_d  = 1'b0;
    ld_d   = 1'b1;
    busy_d = (state != IDLE);
    case (state)
      SETUP: begin
        cs_d  = 1'b0;
        sdi_d = shreg[15];
      end
      SHIFT: begin
        cs_d  = 1'b0;
        sck_d = ~sck_lo;
        sdi_d = shreg[15];
      end
      HOLD:    cs_d = 1'b0;
      LATCH:   ld_d = 1'b0;
      default: ;
    endcase
  end

  // Output registers so every pin is glitch-free
  always_ff @(posedge sysclk) begin
    if (reset) begin
      DAC_CS  <= 1'b1;
      DAC_SCK <= 1'b0;
      DAC_SDI <= 1'b0;
      DAC_LD  <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      DAC_CS  <= cs_d;
      DAC_SCK <= sck_d;
      DAC_SDI <= sdi_d;
      DAC_LD  <= ld_d;
      busy    <= busy_d;
      overrun <= ovr_n;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: drives two DUTs (CLK_DIV=2 and CLK_DIV=1) with the same
// load stream and compares observed frames, busy episodes and overrun pulses
// against a timing-level reference model.
module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [9:0] din = '0;
  int         n_cmp = 0, n_bad = 0, ecnt = 0;

  always #5 clk = ~clk;

  typedef struct {int k; int start; logic [15:0] word; int cs_len; int ld_len; int nbits;} frm_t;
  typedef struct {int k; int start; int len;} ep_t;

  frm_t got_f[$], exp_f[$];
  ep_t  got_b[$], exp_b[$], got_o[$], exp_o[$];
  int   cs_falls[2] = '{0, 0};
  int   exp_falls[2] = '{0, 0};
  int   viol[2] = '{0, 0};

  // model state: frame in flight (start edge, word), pending sample
  logic        fv[2] = '{1'b0, 1'b0};
  int          ft[2];
  logic [15:0] fw[2];
  logic        pv[2] = '{1'b0, 1'b0};
  logic [9:0]  pd[2];

  function automatic int div(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int D = (k == 0) ? 2 : 1;
    logic cs, sck, sdi, ld, busy, ovr;

    dac_spi_tx #(.CLK_DIV(D)) u_dut (
      .sysclk(clk), .reset(rst), .data_in(din), .load(load),
      .busy(busy), .overrun(ovr),
      .DAC_CS(cs), .DAC_SCK(sck), .DAC_SDI(sdi), .DAC_LD(ld)
    );

    logic        pcs = 1'b1, psck = 1'b0, psdi = 1'b0, pld = 1'b1, pbusy = 1'b0;
    int          cs_st = 0, ld_st = 0, b_st = 0, last_e = 0, nb = 0, cs_len = 0;
    logic [15:0] bits = '0;

    // protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
      if (rst) begin
        if (pbusy) got_b.push_back('{k, b_st, ecnt - b_st});
        pcs = 1'b1; psck = 1'b0; psdi = 1'b0; pld = 1'b1; pbusy = 1'b0;
      end else begin
        if (busy && !pbusy) b_st = ecnt;
        if (!busy && pbusy) got_b.push_back('{k, b_st, ecnt - b_st});
        if (pcs && !cs) begin
          cs_st = ecnt; last_e = ecnt; nb = 0; bits = '0;
          cs_falls[k]++;
        end
        if (!cs && sck != psck) begin
          if (ecnt - last_e != D) viol[k]++;
          last_e = ecnt;
          if (sck) begin
            bits = {bits[14:0], sdi};
            nb++;
          end
        end
        if (!pcs && cs) begin
          cs_len = ecnt - cs_st;
          if (ecnt - last_e != 2 * D) viol[k]++;
        end
        if (!pcs && !cs && sdi != psdi && !(psck && !sck)) viol[k]++;
        if (cs && sck) viol[k]++;
        if (sdi && (cs || (ecnt - cs_st >= 33 * D))) viol[k]++;
        if (!ld && !cs) viol[k]++;
        if (pld && !ld) ld_st = ecnt;
        if (!pld && ld) got_f.push_back('{k, cs_st, bits, cs_len, ecnt - ld_st, nb});
        if (ovr) got_o.push_back('{k, ecnt, 0});
        pcs = cs; psck = sck; psdi = sdi; pld = ld; pbusy = busy;
      end
    end
  end

  // reference model, evaluated once per sampled edge s
  task automatic model(input int s);
    for (int k = 0; k < 2; k++) begin
      int D;
      D = div(k);
      if (fv[k] && s > ft[k] + 35 * D) begin
        exp_f.push_back('{k, ft[k] + 1, fw[k], 34 * D, D, 16});
        exp_b.push_back('{k, ft[k] + 1, 35 * D});
        fv[k] = 1'b0;
      end
      if (rst) begin
        if (fv[k]) exp_b.push_back('{k, ft[k] + 1, s - ft[k] - 1});
        fv[k] = 1'b0;
        pv[k] = 1'b0;
      end else if (!fv[k]) begin
        if (pv[k] || load) begin
          fv[k] = 1'b1;
          ft[k] = s;
          fw[k] = 16'h7000 | ({6'd0, (pv[k] ? pd[k] : din)} << 2);
          exp_falls[k]++;
          if (pv[k]) begin
            pv[k] = load;
            pd[k] = din;
          end
        end
      end else if (load) begin
        if (pv[k]) exp_o.push_back('{k, s, 0});
        pv[k] = 1'b1;
        pd[k] = din;
      end
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic [9:0] d);
    rst = r; load = l; din = d;
    @(posedge clk);
    ecnt++;
    model(ecnt);
    #6;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 10'($urandom));
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_d2"}, {g_dut[0].cs, g_dut[0].sck, g_dut[0].sdi, g_dut[0].ld, g_dut[0].busy, g_dut[0].ovr}, 6'b100100);
    chk({tag, "_d1"}, {g_dut[1].cs, g_dut[1].sck, g_dut[1].sdi, g_dut[1].ld, g_dut[1].busy, g_dut[1].ovr}, 6'b100100);
  endtask

  initial begin
    frm_t        gf[$], xf[$];
    ep_t         gb[$], xb[$];
    logic [9:0]  vals[4];
    vals = '{10'h200, 10'h3FF, 10'h000, 10'h1A5};

    // reset with load held high
    repeat (3) begin
      tick(1'b1, 1'b1, 10'($urandom));
      chk_rst_outs("reset_outs");
    end
    repeat (5) begin
      idle(1);
      chk("idle_busy", {g_dut[0].busy, g_dut[1].busy, g_dut[0].cs, g_dut[1].cs}, 4'b0011);
    end

    // single frames: mid-scale, extremes, odd pattern
    foreach (vals[i]) begin
      tick(1'b0, 1'b1, vals[i]);
      idle(80);
    end

    // pending and overrun
    tick(1'b0, 1'b1, 10'h100); idle(9);
    tick(1'b0, 1'b1, 10'h155); idle(9);
    tick(1'b0, 1'b1, 10'h2AA);
    chk("overrun_pulse", {g_dut[0].ovr, g_dut[1].ovr}, 2'b11);
    idle(170);

    // reset mid-SHIFT with a sample pending
    tick(1'b0, 1'b1, 10'h2C3); idle(9);
    tick(1'b0, 1'b1, 10'h0F0); idle(19);
    tick(1'b1, 1'b0, 10'h000);
    chk_rst_outs("midshift_rst");
    idle(150);

    // random load stream
    repeat (800) tick(1'b0, ($urandom_range(0, 29) == 0), 10'($urandom));
    idle(200);

    for (int k = 0; k < 2; k++) begin
      gf = got_f.find with (item.k == k);
      xf = exp_f.find with (item.k == k);
      chk($sformatf("k%0d_nframes", k), gf.size(), xf.size());
      for (int i = 0; i < gf.size() && i < xf.size(); i++) begin
        chk($sformatf("k%0d_f%0d_start", k, i), gf[i].start, xf[i].start);
        chk($sformatf("k%0d_f%0d_word", k, i), gf[i].word, xf[i].word);
        chk($sformatf("k%0d_f%0d_nbits", k, i), gf[i].nbits, xf[i].nbits);
        chk($sformatf("k%0d_f%0d_cs_len", k, i), gf[i].cs_len, xf[i].cs_len);
        chk($sformatf("k%0d_f%0d_ld_len", k, i), gf[i].ld_len, xf[i].ld_len);
      end
      gb = got_b.find with (item.k == k);
      xb = exp_b.find with (item.k == k);
      chk($sformatf("k%0d_nbusy", k), gb.size(), xb.size());
      for (int i = 0; i < gb.size() && i < xb.size(); i++) begin
        chk($sformatf("k%0d_b%0d_start", k, i), gb[i].start, xb[i].start);
        chk($sformatf("k%0d_b%0d_len", k, i), gb[i].len, xb[i].len);
      end
      gb = got_o.find with (item.k == k);
      xb = exp_o.find with (item.k == k);
      chk($sformatf("k%0d_novr", k), gb.size(), xb.size());
      for (int i = 0; i < gb.size() && i < xb.size(); i++)
        chk($sformatf("k%0d_o%0d_edge", k, i), gb[i].start, xb[i].start);
      chk($sformatf("k%0d_cs_falls", k), cs_falls[k], exp_falls[k]);
      chk($sformatf("k%0d_protocol_viol", k), viol[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial output stage that takes each processed 10-bit audio sample from the processor (the offset-binary `data_out` word, qualified by a one-cycle load strobe) and ships it to an MCP4911 10-bit SPI DAC. It formats a 16-bit DAC command word, generates CS/SCK/SDI at a programmable rate, and pulses LDAC to update the analogue output. A one-entry pending buffer absorbs a sample that arrives while a frame is in flight.

## Interface
- `CLK_DIV`, default 25: SCK half-period in `sysclk` cycles; legal range ≥1. At 50 MHz this gives 1 MHz SCK.
- `sysclk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  10  unsigned offset-binary sample, 0x200 = mid-scale.
- `load`  in  1  one-cycle strobe; `data_in` is valid in the same cycle.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `overrun`  out  1  one-cycle pulse when a pending sample is overwritten.
- `DAC_CS`  out  1  SPI chip select, active low.
- `DAC_SCK`  out  1  SPI clock, idles low.
- `DAC_SDI`  out  1  SPI data, MSB first.
- `DAC_LD`  out  1  LDAC, active low.

Every output is driven directly from a register.

## Operation
- **Command word:** `{1'b0, BUF=1, GA_n=1, SHDN_n=1, data_in[9:0], 2'b00}`, so `word = 16'h7000 | (data_in << 2)`.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD, LATCH.
  - **IDLE:** `CS`=1, `SCK`=0, `SDI`=0, `LD`=1.
    - If `load` is high or pending is valid, load the shift register with the word and go to SETUP.
    - A pending sample takes priority and is then cleared. A `load` arriving in that same cycle becomes the new pending sample.
  - **SETUP:** lasts `CLK_DIV` cycles. `CS`=0, `SCK`=0, `SDI`=word[15].
  - **SHIFT:** 16 bits.
    - Each bit is `CLK_DIV` cycles with `SCK`=1, followed by `CLK_DIV` cycles with `SCK`=0.
    - On each SCK high-to-low transition, the shift register shifts left and `SDI` presents the next bit.
    - After the 16th low phase, go to HOLD. `SDI` = 0 from this point.
  - **HOLD:** lasts `CLK_DIV` cycles. `CS`=0, `SCK`=0.
  - **LATCH:** lasts `CLK_DIV` cycles. `CS`=1, `LD`=0. Then return to IDLE.
- **Counters:**
  - Prescaler: `$clog2(CLK_DIV+1)` bits, runs 0..`CLK_DIV`-1.
  - Bit counter: 4 bits, 15..0. Wrap-around at 0 terminates SHIFT.
- **`load` while `busy`:**
  - The sample is captured into the pending register.
  - If pending is already valid, the newest sample overwrites it and `overrun` pulses in that cycle.
  - Samples are never queued deeper than one.
- **`load` high for several consecutive cycles:** each cycle counts as a separate load.
- **`reset`:** has priority over everything.
  - Next edge: FSM in IDLE, `CS`=1, `SCK`=0, `SDI`=0, `LD`=1, `busy`=0, `overrun`=0, pending cleared, counters 0.
  - A frame aborted mid-way produces no LDAC pulse.

## Timing
- **Latency:** with `load` sampled at edge N, `busy` and `CS`=0 appear after edge N+1, and `SDI`=word[15] is valid from N+1.
- **SCK edges:** first rising edge at N+1+`CLK_DIV`. The DAC samples on rising SCK.
  - `SDI` setup and hold are each `CLK_DIV` cycles around every rising edge.
- **Frame length** (`CS` low to `LD` return high): exactly 35·`CLK_DIV` cycles, made up of:
  - 1 SETUP phase
  - 32 SHIFT phases
  - 1 HOLD phase
  - 1 LATCH phase
- **`busy`** is high for exactly 35·`CLK_DIV` cycles per frame.
- **Back-to-back frames:** a pending sample starts its frame with one IDLE cycle between frames. `CS` is high for `CLK_DIV`+1 cycles between frames.
- **Throughput:** default `CLK_DIV` gives 876 cycles per sample, comfortably above the ADC sample period.

## Test plan
- **Reset values:** assert `reset` 3 cycles with `load`=1 → all outputs at reset values, no `CS` activity; after release, with `load` held low, `busy` stays 0.
- **Mid-scale frame:** `CLK_DIV`=2, `load` with `data_in`=0x200 → 16 bits sampled on SCK rising edges equal 0x7800; `CS` low 68 cycles; `LD` low 2 cycles; `busy` high 70 cycles.
- **Code extremes:** `data_in`=0x3FF → 0x7FFC; `data_in`=0x000 → 0x7000; `SDI`=0 outside SETUP/SHIFT.
- **Pending and overrun:** `CLK_DIV`=2, loads 0x100, 0x155, 0x2AA at cycles 0, 10, 20 → `overrun` pulses at cycle 20; the second frame carries 0x2AA (word 0x7AA8); exactly 2 frames are sent, separated by 1 IDLE cycle.
- **Reset mid-SHIFT:** assert `reset` during bit 7 → next cycle `CS`=1, `SCK`=0, `busy`=0; no `LD` pulse; the pending sample is discarded (no further frame).
- **Minimum divider:** `CLK_DIV`=1, `data_in`=0x1A5 → word 0x7694; SCK toggles every cycle; frame is 35 cycles.
